// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL lock sequencer: state encoding and parameter defaults.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_PWRDN   = 3'd1,
    ST_RESET   = 3'd2,
    ST_MEASURE = 3'd3,
    ST_LOCKED  = 3'd4,
    ST_FAIL    = 3'd5
  } state_e;

  localparam int DEF_CNT_W       = 16;
  localparam int DEF_PD_CYC      = 8;
  localparam int DEF_RST_CYC     = 16;
  localparam int DEF_LOCK_CNT    = 4;
  localparam int DEF_TOL         = 1;
  localparam int DEF_TIMEOUT_CYC = 1024;

endpackage

// File: rtl/pll_lock_seq_period_meter.sv
// Measures the monitored-clock period in clk cycles, judges stability against the
// previous capture and flags a missing-edge timeout.
module period_meter
  import pll_seq_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TOL         = DEF_TOL,
  parameter int LOCK_CNT    = DEF_LOCK_CNT,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_run,
  input  logic             i_mon_edge,
  output logic [CNT_W-1:0] o_period,
  output logic             o_capture,
  output logic             o_stable,
  output logic             o_lock_hit,
  output logic             o_timeout
);

  localparam logic [CNT_W-1:0] ONE_V  = CNT_W'(1);
  localparam logic [CNT_W-1:0] TOL_V  = CNT_W'(TOL);
  localparam logic [CNT_W-1:0] LOCK_V = CNT_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0] TMO_V  = CNT_W'(TIMEOUT_CYC);

  logic [CNT_W-1:0] r_gap;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_stable_cnt;
  logic             r_armed;
  logic             r_have_prev;

  logic [CNT_W-1:0] w_diff;
  logic [CNT_W-1:0] w_gap_inc;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_capture;
  logic             w_stable;

  // The first edge after a clear only arms the meter; later edges capture.
  assign w_capture = i_run && i_mon_edge && r_armed;
  assign w_diff    = (r_gap >= r_period) ? (r_gap - r_period) : (r_period - r_gap);
  assign w_stable  = w_capture && r_have_prev && (r_gap != '0) && (w_diff <= TOL_V);
  assign w_gap_inc = (&r_gap) ? r_gap : (r_gap + ONE_V);
  assign w_cnt_inc = (&r_stable_cnt) ? r_stable_cnt : (r_stable_cnt + ONE_V);

  assign o_period   = r_period;
  assign o_capture  = w_capture;
  assign o_stable   = w_stable;
  assign o_lock_hit = w_stable && (w_cnt_inc >= LOCK_V);
  assign o_timeout  = i_run && !i_mon_edge && (r_gap >= TMO_V);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gap        <= '0;
      r_period     <= '0;
      r_stable_cnt <= '0;
      r_armed      <= 1'b0;
      r_have_prev  <= 1'b0;
    end else if (i_clr) begin
      r_gap        <= '0;
      r_stable_cnt <= '0;
      r_armed      <= 1'b0;
      r_have_prev  <= 1'b0;
    end else if (i_run) begin
      r_gap <= i_mon_edge ? ONE_V : w_gap_inc;
      if (i_mon_edge) begin
        if (!r_armed) begin
          r_armed <= 1'b1;
        end else begin
          r_period     <= r_gap;
          r_have_prev  <= 1'b1;
          r_stable_cnt <= w_stable ? w_cnt_inc : '0;
        end
      end
    end
  end

endmodule

// File: rtl/pll_lock_seq.sv
// PLL power-up / reset / lock-detect sequencer.
// Optional macro PLL_LOCK_SEQ_AUTO_RELOCK_EN: loss of lock restarts from PWRDN instead of FAIL.
module pll_lock_seq
  import pll_seq_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int PD_CYC      = DEF_PD_CYC,
  parameter int RST_CYC     = DEF_RST_CYC,
  parameter int LOCK_CNT    = DEF_LOCK_CNT,
  parameter int TOL         = DEF_TOL,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mon_edge,
  output logic             pll_pwrdwn,
  output logic             pll_rst,
  output logic             locked,
  output logic             fail,
  output logic [CNT_W-1:0] period,
  output logic [2:0]       state
);

  localparam int TMR_MAX = (PD_CYC > RST_CYC) ? PD_CYC : RST_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] PD_LAST  = TMR_W'(PD_CYC - 1);
  localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(RST_CYC - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [TMR_W-1:0] r_tmr;
  logic             r_pwrdwn;
  logic             r_rst;
  logic             r_locked;
  logic             r_fail;

  logic w_pwrdwn_nxt;
  logic w_rst_nxt;
  logic w_locked_nxt;
  logic w_fail_nxt;
  logic w_clr;
  logic w_run;
  logic w_capture;
  logic w_stable;
  logic w_lock_hit;
  logic w_timeout;

  assign w_run = (r_state == ST_MEASURE) || (r_state == ST_LOCKED);
  assign w_clr = (w_state_nxt == ST_MEASURE) && (r_state != ST_MEASURE);

  period_meter #(
    .CNT_W       (CNT_W),
    .TOL         (TOL),
    .LOCK_CNT    (LOCK_CNT),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_meter (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_clr),
    .i_run      (w_run),
    .i_mon_edge (mon_edge),
    .o_period   (period),
    .o_capture  (w_capture),
    .o_stable   (w_stable),
    .o_lock_hit (w_lock_hit),
    .o_timeout  (w_timeout)
  );

  // Dwell timer restarts on every state change so each timed state starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmr <= '0;
    end else if (w_state_nxt != r_state) begin
      r_tmr <= '0;
    end else if ((r_state == ST_PWRDN) || (r_state == ST_RESET)) begin
      r_tmr <= r_tmr + TMR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_OFF;
      r_pwrdwn <= 1'b1;
      r_rst    <= 1'b1;
      r_locked <= 1'b0;
      r_fail   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pwrdwn <= w_pwrdwn_nxt;
      r_rst    <= w_rst_nxt;
      r_locked <= w_locked_nxt;
      r_fail   <= w_fail_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!en) begin
      w_state_nxt = ST_OFF;
    end else begin
      case (r_state)
        ST_OFF:     w_state_nxt = ST_PWRDN;
        ST_PWRDN:   if (r_tmr == PD_LAST) w_state_nxt = ST_RESET;
        ST_RESET:   if (r_tmr == RST_LAST) w_state_nxt = ST_MEASURE;
        ST_MEASURE: begin
          if (w_timeout)       w_state_nxt = ST_FAIL;
          else if (w_lock_hit) w_state_nxt = ST_LOCKED;
        end
        ST_LOCKED: begin
          if ((w_capture && !w_stable) || w_timeout) begin
`ifdef PLL_LOCK_SEQ_AUTO_RELOCK_EN
            w_state_nxt = ST_PWRDN;
`else
            w_state_nxt = ST_FAIL;
`endif
          end
        end
        ST_FAIL:    w_state_nxt = ST_FAIL;
        default:    w_state_nxt = ST_OFF;
      endcase
    end
  end

  // Outputs are decoded from the next state and registered alongside it.
  always_comb begin
    w_pwrdwn_nxt = 1'b0;
    w_rst_nxt    = 1'b0;
    w_locked_nxt = 1'b0;
    w_fail_nxt   = 1'b0;
    case (w_state_nxt)
      ST_OFF, ST_PWRDN, ST_FAIL: begin
        w_pwrdwn_nxt = 1'b1;
        w_rst_nxt    = 1'b1;
      end
      ST_RESET:  w_rst_nxt = 1'b1;
      default:   ;
    endcase
    w_locked_nxt = (w_state_nxt == ST_LOCKED);
    w_fail_nxt   = (w_state_nxt == ST_FAIL);
  end

  assign pll_pwrdwn = r_pwrdwn;
  assign pll_rst    = r_rst;
  assign locked     = r_locked;
  assign fail       = r_fail;
  assign state      = r_state;

endmodule

// File: tb/tb_pll_lock_seq.sv
// Self-checking bench for pll_lock_seq: directed vector table, hand sequences and
// randomized monitored-clock traffic checked against a time-stamp based reference model.
module tb_pll_lock_seq;

  localparam int CNT_W = 16;
  localparam int PD    = 4;
  localparam int RSTC  = 4;
  localparam int LOCKN = 3;
  localparam int TOLV  = 1;
  localparam int TMO   = 64;
`ifdef PLL_LOCK_SEQ_AUTO_RELOCK_EN
  localparam bit RELOCK = 1'b1;
`else
  localparam bit RELOCK = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             mon_edge;
  logic             pll_pwrdwn;
  logic             pll_rst;
  logic             locked;
  logic             fail;
  logic [CNT_W-1:0] period;
  logic [2:0]       state;

  int nChecks = 0;
  int nErrors = 0;

  pll_lock_seq #(
    .CNT_W       (CNT_W),
    .PD_CYC      (PD),
    .RST_CYC     (RSTC),
    .LOCK_CNT    (LOCKN),
    .TOL         (TOLV),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .mon_edge   (mon_edge),
    .pll_pwrdwn (pll_pwrdwn),
    .pll_rst    (pll_rst),
    .locked     (locked),
    .fail       (fail),
    .period     (period),
    .state      (state)
  );

  always #5 clk = ~clk;

  // Reference model works in absolute cycle numbers: entry time of the current
  // state, time of the last monitored edge, and the previous captured period.
  int mState, mEntry, mLastEdge, mPrev, mRun, mPeriod, n;
  bit mArmed;

  task automatic modelReset();
    mState = 0; mEntry = 0; mLastEdge = 0; mPrev = -1; mRun = 0;
    mPeriod = 0; n = 0; mArmed = 1'b0;
  endtask

  task automatic modelStep(input bit e, input bit me);
    int nxt, gap, d;
    bit cap, stb, tmo;
    nxt = mState; cap = 1'b0; stb = 1'b0; tmo = 1'b0;
    if (mState == 3 || mState == 4) begin
      gap = n - mLastEdge;
      tmo = !me && (gap >= TMO);
      if (me) begin
        if (!mArmed) begin
          mArmed = 1'b1;
        end else begin
          d = gap - mPrev;
          if (d < 0) d = -d;
          cap = 1'b1;
          stb = (mPrev >= 0) && (gap != 0) && (d <= TOLV);
          mPrev = gap;
          mPeriod = gap;
          mRun = stb ? mRun + 1 : 0;
        end
        mLastEdge = n;
      end
    end
    if (!e) nxt = 0;
    else case (mState)
      0: nxt = 1;
      1: if (n - mEntry + 1 == PD) nxt = 2;
      2: if (n - mEntry + 1 == RSTC) nxt = 3;
      3: if (tmo) nxt = 5; else if (stb && mRun >= LOCKN) nxt = 4;
      4: if ((cap && !stb) || tmo) nxt = RELOCK ? 1 : 5;
      default: nxt = mState;
    endcase
    if (nxt != mState) begin
      mEntry = n + 1;
      if (nxt == 3) begin
        mLastEdge = n + 1; mArmed = 1'b0; mPrev = -1; mRun = 0;
      end
    end
    mState = nxt;
    n++;
  endtask

  task automatic cmp(input string tag, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, n);
    end
  endtask

  task automatic checkOutput(input string tag);
    bit ePd, eRst;
    ePd  = (mState == 0) || (mState == 1) || (mState == 5);
    eRst = ePd || (mState == 2);
    cmp({tag, ".state"},  int'(state), mState);
    cmp({tag, ".pwrdwn"}, int'(pll_pwrdwn), int'(ePd));
    cmp({tag, ".rst"},    int'(pll_rst), int'(eRst));
    cmp({tag, ".locked"}, int'(locked), int'(mState == 4));
    cmp({tag, ".fail"},   int'(fail), int'(mState == 5));
    cmp({tag, ".period"}, int'(period), mPeriod);
  endtask

  task automatic applyStimulus(input bit e, input bit me);
    en = e;
    mon_edge = me;
    @(posedge clk);
    modelStep(e, me);
    #1;
    checkOutput("model");
  endtask

  task automatic sendPeriod(input int p);
    for (int k = 0; k < p - 1; k++) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
  endtask

  typedef struct {
    bit e;
    bit me;
    int expState;
    bit expPwrdn;
    bit expRst;
  } vec_t;

  vec_t tbl[9];
  int   pers[8];

  initial begin
    int cd, base;
    bit me, e;

    for (int i = 0; i < 9; i++)
      tbl[i] = '{1'b1, 1'b0, (i < 4) ? 1 : (i < 8) ? 2 : 3, (i < 4), (i < 8)};
    pers = '{10, 10, 10, 12, 10, 10, 10, 10};

    rst_n = 1'b0; en = 1'b0; mon_edge = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    cmp("rstState", int'(state), 0);
    cmp("rstPwrdn", int'(pll_pwrdwn), 1);
    cmp("rstRst", int'(pll_rst), 1);
    cmp("rstLocked", int'(locked), 0);
    cmp("rstFail", int'(fail), 0);
    cmp("rstPeriod", int'(period), 0);
    rst_n = 1'b1;

    // Power-down then reset dwell times
    for (int i = 0; i < 9; i++) begin
      applyStimulus(tbl[i].e, tbl[i].me);
      cmp("vecState", int'(state), tbl[i].expState);
      cmp("vecPwrdn", int'(pll_pwrdwn), int'(tbl[i].expPwrdn));
      cmp("vecRst", int'(pll_rst), int'(tbl[i].expRst));
    end

    // Steady 10-cycle edges: arm, first capture, three stable captures
    for (int k = 1; k <= 5; k++) begin
      sendPeriod(10);
      cmp("lockEdge", int'(locked), int'(k == 5));
    end
    cmp("lockPeriod", int'(period), 10);

    // Edges stop while locked
    repeat (TMO - 1) applyStimulus(1'b1, 1'b0);
    cmp("preTmoLocked", int'(locked), 1);
    applyStimulus(1'b1, 1'b0);
    cmp("tmoLocked", int'(locked), 0);
`ifdef PLL_LOCK_SEQ_AUTO_RELOCK_EN
    cmp("tmoState", int'(state), 1);
`else
    cmp("tmoFail", int'(fail), 1);
    cmp("tmoState", int'(state), 5);
`endif
    applyStimulus(1'b0, 1'b0);
    cmp("offState", int'(state), 0);

    // Stability run broken by a 12-cycle period
    repeat (9) applyStimulus(1'b1, 1'b0);
    cmp("measState", int'(state), 3);
    for (int i = 0; i < 8; i++) begin
      sendPeriod(pers[i]);
      cmp("relockSeq", int'(locked), int'(i == 7));
    end
    cmp("relockPeriod", int'(period), 10);

    // en drop while locked
    applyStimulus(1'b0, 1'b0);
    cmp("enOffState", int'(state), 0);
    cmp("enOffPwrdn", int'(pll_pwrdwn), 1);
    cmp("enOffRst", int'(pll_rst), 1);
    cmp("enOffLocked", int'(locked), 0);

    // Asynchronous reset in the middle of RESET
    repeat (6) applyStimulus(1'b1, 1'b0);
    cmp("midResetState", int'(state), 2);
    #1;
    rst_n = 1'b0;
    #1;
    cmp("asyncState", int'(state), 0);
    cmp("asyncPwrdn", int'(pll_pwrdwn), 1);
    cmp("asyncRst", int'(pll_rst), 1);
    cmp("asyncLocked", int'(locked), 0);
    cmp("asyncFail", int'(fail), 0);
    cmp("asyncPeriod", int'(period), 0);
    en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    modelReset();
    rst_n = 1'b1;

    // Randomized traffic: jittery periods, occasional long gaps and en drops
    for (int t = 0; t < 8; t++) begin
      base = $urandom_range(4, 20);
      cd = 0;
      for (int c = 0; c < 400; c++) begin
        me = (cd == 0);
        if (me) cd = (($urandom_range(0, 29) == 0) ? 70 : base + $urandom_range(0, 2)) - 1;
        else cd--;
        e = ($urandom_range(0, 199) != 0);
        applyStimulus(e, me);
      end
      applyStimulus(1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/pll_lock_seq.md
PLL_LOCK_SEQ -- requirements
Module: pll_lock_seq

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of period counter and period output.
REQ-002 SHALL have parameter PD_CYC, default 8, clk cycles pll_pwrdwn is held in PWRDN.
REQ-003 SHALL have parameter RST_CYC, default 16, clk cycles pll_rst is held in RESET.
REQ-004 SHALL have parameter LOCK_CNT, default 4, consecutive stable periods required to lock.
REQ-005 SHALL have parameter TOL, default 1, maximum absolute period difference still counted as stable.
REQ-006 SHALL have parameter TIMEOUT_CYC, default 1024, maximum clk cycles between mon_edge pulses.
REQ-007 SHALL have port clk  in  1  single block clock, all logic on its rising edge.
REQ-008 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-009 SHALL have ports en  in  1  sequence enable; mon_edge  in  1  one-cycle pulse per monitored-clock rising edge, already synchronised to clk.
REQ-010 SHALL have ports pll_pwrdwn  out  1; pll_rst  out  1; locked  out  1; fail  out  1; period  out  CNT_W  last captured period; state  out  3  current FSM state.

Function
REQ-011 SHALL implement FSM states OFF=0, PWRDN=1, RESET=2, MEASURE=3, LOCKED=4, FAIL=5.
REQ-012 SHALL move to OFF on the next edge whenever en=0, from any state; this has priority over all other transitions.
REQ-013 SHALL move OFF->PWRDN when en=1; PWRDN->RESET after exactly PD_CYC cycles in PWRDN; RESET->MEASURE after exactly RST_CYC cycles in RESET.
REQ-014 SHALL drive pll_pwrdwn=1 in OFF, PWRDN, FAIL, else 0; pll_rst=1 in OFF, PWRDN, RESET, FAIL, else 0 (registered, changing on the same edge as state).
REQ-015 SHALL in MEASURE/LOCKED count clk cycles since the last mon_edge, saturating at all-ones; for edges at cycles t0,t1 the captured period is t1-t0.
REQ-016 SHALL treat the first mon_edge after entering MEASURE as arming only: no period captured, no stability evaluation.
REQ-017 SHALL on each later mon_edge capture period and mark it stable iff period!=0 and |period - previous period| <= TOL, with the very first capture never stable.
REQ-018 SHALL increment the stable counter on a stable capture and clear it on an unstable capture; when it reaches LOCK_CNT, MEASURE->LOCKED with locked=1 on that edge.
REQ-019 SHALL declare timeout when the gap counter reaches TIMEOUT_CYC without mon_edge; a mon_edge in the same cycle cancels the timeout.
REQ-020 SHALL in MEASURE on timeout go to FAIL; in LOCKED on unstable capture or timeout deassert locked on the next edge and go to FAIL (see REQ-026).
REQ-021 SHALL assert fail=1 only in FAIL; FAIL exits only via en=0.
REQ-022 SHALL clear gap counter, stable counter and arming flag on every entry to MEASURE; period holds its last value until next capture.

Reset
REQ-023 SHALL on rst_n=0 immediately force state=OFF, pll_pwrdwn=1, pll_rst=1, locked=0, fail=0, period=0, all counters and flags 0.
REQ-024 SHALL on rst_n release mid-sequence restart from OFF; no partial timer or lock state survives.

Configuration
REQ-025 SHALL support macro PLL_LOCK_SEQ_AUTO_RELOCK_EN.
REQ-026 SHALL with the macro defined route loss of lock from LOCKED to PWRDN instead of FAIL (MEASURE timeout still goes to FAIL); without it LOCKED loss goes to FAIL.

Structure
REQ-027 SHALL place the state enum encoding and parameter defaults in shared package pll_seq_pkg.
REQ-028 SHALL implement gap counter, capture and stable comparison in sub-module period_meter; FSM and timers stay in pll_lock_seq.

Verification
REQ-029 SHALL verify: PD_CYC=4,RST_CYC=4, en rises -> pll_pwrdwn high 4 cycles in PWRDN, then pll_rst high 4 more, state=3.
REQ-030 SHALL verify: LOCK_CNT=3,TOL=1, mon_edge every 10 cycles -> locked=1 on the 5th edge (arm, first capture, 3 stable), period=10.
REQ-031 SHALL verify: periods 10,10,12,10,10,10 -> stable counter clears at 12, lock on the edge completing 3 further stable captures.
REQ-032 SHALL verify: TIMEOUT_CYC=64, edges stop in LOCKED -> locked=0 and fail=1 after 64 idle cycles (no macro); with macro state=1 instead.
REQ-033 SHALL verify: en=0 in LOCKED -> state=0, pll_pwrdwn=pll_rst=1, locked=0 next edge; rst_n pulse mid-RESET -> all outputs at reset values immediately.
